vinsn_issuer: RTL and testbench
===============================

# vinsn_issuer

Issue stage sitting between the vector decoder and the VFUs, acting as the issuing side of the scoreboard handshake. Holds one decoded instruction, allocates it an instruction ID from a free pool, presents it to the scoreboard, and grants it once the scoreboard does not stall and the target VFU is ready. VFU completions return IDs to the pool.

## Interface
- `NrVFU`, package value: number of functional units.
- `InsnIDNum`, package value: size of the instruction-ID pool.
- `StallCntWidth`, 32: width of the stall-cycle counter; used only when the counter is enabled.

Ports:
- `clk_i` input, 1 bit: clock.
- `rst_i` input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `dec_req_i` input, `issue_req_t`: decoded instruction. Its `insn_id` field is ignored.
- `dec_vfu_i` input, `NrVFU` bits: one-hot target VFU.
- `dec_valid_i` input, 1 bit: decoder holds a valid instruction.
- `dec_ready_o` output, 1 bit: issuer accepts the instruction.
- `issue_req_o` output, `issue_req_t`: held instruction with `insn_id` filled in. Goes to the scoreboard and the VFUs.
- `issue_valid_o` output, 1 bit: holding register is occupied.
- `stall_i` input, 1 bit: scoreboard hazard stall.
- `vfu_ready_i` input, `NrVFU` bits: per-VFU ready.
- `issue_req_gnt_o` output, 1 bit: instruction issued this cycle. Goes to the scoreboard.
- `vfu_valid_o` output, `NrVFU` bits: one-hot dispatch strobe, equal to `gnt` masked by the target.
- `insn_done_i` input, `NrVFU` bits: per-VFU completion.
- `insn_done_id_i` input, `NrVFU` × `insn_id_t`: ID of the completed instruction.
- `idle_o` output, 1 bit: holding register empty and all IDs free.
- `stall_cycles_o` output, `StallCntWidth` bits: present only when the counter is enabled.

## Operation
- **State machine:** two states.
  - `EMPTY → HELD` on capture.
  - `HELD → EMPTY` on grant without a same-cycle capture.
  - `HELD → HELD` on grant with capture, or when there is no grant.
- **ID free pool:** `free_q` bitmap of `InsnIDNum` bits, all ones at reset.
- **Capture:**
  - Condition: `dec_valid_i && dec_ready_o`.
  - Loads `dec_req_i`, `dec_vfu_i`, and the lowest-index set bit of `free_q` as `insn_id`.
  - Clears that bit.
- **`dec_ready_o`:** `(state==EMPTY || issue_req_gnt_o) && |free_q`.
  - An ID freed this cycle is not visible to allocation until the next cycle.
- **`issue_req_gnt_o`:** `issue_valid_o && !stall_i && |(vfu_ready_i & target)`.
  - Must not depend combinationally on `dec_valid_i` or `insn_done_i`.
- **Retire:** `insn_done_i[i]` sets `free_q[insn_done_id_i[i]]`.
  - Multiple retires in the same cycle are OR-ed.
  - Retiring an already-free ID is a no-op.
  - Retire and allocate of different IDs in the same cycle both take effect.
- **Illegal input:** `dec_vfu_i` that is not one-hot gives undefined dispatch. With the counter enabled, this is flagged by an assertion.
- **Reset mid-operation:** the held instruction is dropped and all IDs are freed. Any instructions still in flight in the VFUs must be reset by the same reset.

## Timing
- **Reset values:**
  - `issue_valid_o=0`, `issue_req_gnt_o=0`, `vfu_valid_o=0`.
  - `dec_ready_o=1` (pool full).
  - `idle_o=1`.
  - `stall_cycles_o=0`.
  - `issue_req_o` is don't-care.
- **Latency:** capture at edge N gives `issue_valid_o` in cycle N+1. The earliest grant is in cycle N+1.
- **Throughput:** one issue per cycle while IDs remain and there are no stalls.
- **Hold stability:** `issue_req_o` is stable while `issue_valid_o && !issue_req_gnt_o`.
- **Pool exhausted:** `dec_ready_o=0` until the cycle after a retire.

## Configuration
- `VINSN_ISSUER_STALL_CNT_EN` defined:
  - `stall_cycles_o` increments every cycle with `issue_valid_o && !issue_req_gnt_o`.
  - It saturates at all ones.
  - The one-hot assertion on `dec_vfu_i` is compiled in.
- Not defined: no port, no counter, no assertion.

## Structure
- **Existing package items:** `issue_req_t`, `insn_id_t`, `InsnIDNum`, `NrVFU` stay in `core_pkg`/`rvv_pkg`.
- **New package item:** add `vfu_mask_t` (`logic [NrVFU-1:0]`) to `core_pkg`.
- **Sub-module:** `insn_id_alloc`. It holds the free bitmap, the find-first-free encoder, and the retire merge.

## Test plan
Bench uses `InsnIDNum=4`, `NrVFU=2`.
- **Back-to-back issue:** after reset, 4 back-to-back decodes to VFU0 with `stall_i=0` and `vfu_ready_i=2'b11` → grants on cycles 1–4 with IDs 0,1,2,3. A 5th decode sees `dec_ready_o=0`.
- **Free-then-reuse:** pool exhausted, then `insn_done_i=2'b01` with id 2 → `dec_ready_o=1` the next cycle; the next capture gets ID 2.
- **Scoreboard stall:** `stall_i=1` for 3 cycles with an instruction held → no grant, `issue_req_o` unchanged, `stall_cycles_o=3` when the counter is enabled. Grant occurs the cycle `stall_i` drops.
- **Target not ready:** target VFU1 with `vfu_ready_i=2'b01` → no grant. Raising bit 1 → `vfu_valid_o=2'b10` for one cycle.
- **Simultaneous retires plus capture:** both VFUs retire IDs 0 and 3 in the same cycle as a capture → both IDs freed; the capture takes the lowest ID that was free before the edge.
- **Reset mid-hold:** `rst_i` pulsed with an instruction held → next cycle `issue_valid_o=0`, `idle_o=1`, `dec_ready_o=1`.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide vector issue types: instruction request, instruction ID and VFU mask.
package core_pkg;

    localparam int unsigned NrVFU       = 2;
    localparam int unsigned InsnIDNum   = 4;
    localparam int unsigned InsnIDWidth = (InsnIDNum > 1) ? $clog2(InsnIDNum) : 1;

    typedef logic [InsnIDWidth-1:0] insn_id_t;
    typedef logic [NrVFU-1:0]       vfu_mask_t;

    typedef struct packed {
        insn_id_t   insn_id;
        logic [6:0] op;
        logic [4:0] vd;
        logic [4:0] vs2;
        logic [4:0] vs1;
    } issue_req_t;

endpackage

// File: rtl/insn_id_alloc.sv
// Instruction-ID free pool: free bitmap, lowest-free encoder and retire merge.
module insn_id_alloc
    import core_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      alloc_i,
    input  vfu_mask_t                 retire_i,
    input  insn_id_t [NrVFU-1:0]      retire_id_i,
    output logic [InsnIDNum-1:0]      free_o,
    output insn_id_t                  alloc_id_o,
    output logic                      any_free_o
);

    logic [InsnIDNum-1:0] free_q;
    logic [InsnIDNum-1:0] free_d;
    logic                 found;

    always_comb begin
        alloc_id_o = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < InsnIDNum; i++) begin
            if (free_q[i] && !found) begin
                alloc_id_o = insn_id_t'(i);
                found      = 1'b1;
            end
        end
    end

    // Retires merge first, then the allocated bit is cleared; a granted ID can
    // never be the one being allocated, so ordering only matters for no-op retires.
    always_comb begin
        free_d = free_q;
        for (int unsigned i = 0; i < NrVFU; i++) begin
            if (retire_i[i]) free_d[retire_id_i[i]] = 1'b1;
        end
        if (alloc_i) free_d[alloc_id_o] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) free_q <= '1;
        else       free_q <= free_d;
    end

    assign free_o     = free_q;
    assign any_free_o = |free_q;

endmodule

// File: rtl/vinsn_issuer.sv
// Vector instruction issue stage with ID allocation and scoreboard handshake.
// Optional stall-cycle counter and one-hot target check: VINSN_ISSUER_STALL_CNT_EN.
module vinsn_issuer
    import core_pkg::*;
`ifdef VINSN_ISSUER_STALL_CNT_EN
#(
    parameter int unsigned StallCntWidth = 32
)
`endif
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  issue_req_t               dec_req_i,
    input  vfu_mask_t                dec_vfu_i,
    input  logic                     dec_valid_i,
    output logic                     dec_ready_o,
    output issue_req_t               issue_req_o,
    output logic                     issue_valid_o,
    input  logic                     stall_i,
    input  vfu_mask_t                vfu_ready_i,
    output logic                     issue_req_gnt_o,
    output vfu_mask_t                vfu_valid_o,
    input  vfu_mask_t                insn_done_i,
    input  insn_id_t [NrVFU-1:0]     insn_done_id_i,
`ifdef VINSN_ISSUER_STALL_CNT_EN
    output logic [StallCntWidth-1:0] stall_cycles_o,
`endif
    output logic                     idle_o
);

    typedef enum logic {EMPTY, HELD} state_e;

    state_e               state_q;
    issue_req_t           req_q;
    vfu_mask_t            vfu_q;
    logic                 capture;
    logic                 any_free;
    insn_id_t             alloc_id;
    logic [InsnIDNum-1:0] free_q;

    insn_id_alloc u_insn_id_alloc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alloc_i     (capture),
        .retire_i    (insn_done_i),
        .retire_id_i (insn_done_id_i),
        .free_o      (free_q),
        .alloc_id_o  (alloc_id),
        .any_free_o  (any_free)
    );

    assign issue_valid_o   = (state_q == HELD);
    assign issue_req_gnt_o = issue_valid_o && !stall_i && |(vfu_ready_i & vfu_q);
    assign vfu_valid_o     = {NrVFU{issue_req_gnt_o}} & vfu_q;
    assign dec_ready_o     = (state_q == EMPTY || issue_req_gnt_o) && any_free;
    assign capture         = dec_valid_i && dec_ready_o;
    assign issue_req_o     = req_q;
    assign idle_o          = (state_q == EMPTY) && (&free_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            if (state_q == EMPTY) begin
                if (capture) state_q <= HELD;
            end else if (issue_req_gnt_o && !capture) begin
                state_q <= EMPTY;
            end
            if (capture) begin
                req_q         <= dec_req_i;
                req_q.insn_id <= alloc_id;
                vfu_q         <= dec_vfu_i;
            end
        end
    end

`ifdef VINSN_ISSUER_STALL_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_o <= '0;
        end else if (issue_valid_o && !issue_req_gnt_o && stall_cycles_o != '1) begin
            stall_cycles_o <= stall_cycles_o + 1'b1;
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i)
        capture |-> $onehot(dec_vfu_i));
`endif

endmodule

// File: tb/tb_vinsn_issuer.sv
// Randomised and directed bench for vinsn_issuer against a free-list reference model.
module tb_vinsn_issuer;
    import core_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    issue_req_t           dec_req_i;
    vfu_mask_t            dec_vfu_i;
    logic                 dec_valid_i;
    logic                 dec_ready_o;
    issue_req_t           issue_req_o;
    logic                 issue_valid_o;
    logic                 stall_i;
    vfu_mask_t            vfu_ready_i;
    logic                 issue_req_gnt_o;
    vfu_mask_t            vfu_valid_o;
    vfu_mask_t            insn_done_i;
    insn_id_t [NrVFU-1:0] insn_done_id_i;
    logic                 idle_o;
`ifdef VINSN_ISSUER_STALL_CNT_EN
    logic [31:0]          stall_cycles_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: held instruction, target index, free-ID set, IDs out in VFUs.
    bit          m_held;
    issue_req_t  m_req;
    int          m_tgt;
    bit          m_free [InsnIDNum];
    int unsigned m_stall;
    int          inflight [$];

    logic        o_gnt, o_rdy;
    insn_id_t    o_id;
    vfu_mask_t   o_vfu;

    vinsn_issuer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .dec_req_i       (dec_req_i),
        .dec_vfu_i       (dec_vfu_i),
        .dec_valid_i     (dec_valid_i),
        .dec_ready_o     (dec_ready_o),
        .issue_req_o     (issue_req_o),
        .issue_valid_o   (issue_valid_o),
        .stall_i         (stall_i),
        .vfu_ready_i     (vfu_ready_i),
        .issue_req_gnt_o (issue_req_gnt_o),
        .vfu_valid_o     (vfu_valid_o),
        .insn_done_i     (insn_done_i),
        .insn_done_id_i  (insn_done_id_i),
`ifdef VINSN_ISSUER_STALL_CNT_EN
        .stall_cycles_o  (stall_cycles_o),
`endif
        .idle_o          (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_held  = 1'b0;
        m_stall = 0;
        foreach (m_free[i]) m_free[i] = 1'b1;
        inflight.delete();
    endfunction

    function automatic int tgt_of(input vfu_mask_t m);
        for (int i = 0; i < NrVFU; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic issue_req_t rand_req();
        issue_req_t r;
        r.insn_id = insn_id_t'($urandom);
        r.op      = 7'($urandom);
        r.vd      = 5'($urandom);
        r.vs2     = 5'($urandom);
        r.vs1     = 5'($urandom);
        return r;
    endfunction

    function automatic void drop(input int id);
        foreach (inflight[i]) if (inflight[i] == id) begin
            inflight.delete(i);
            return;
        end
    endfunction

    task automatic retire_pick(input int v);
        int idx;
        if (inflight.size() == 0) return;
        idx = $urandom_range(inflight.size() - 1);
        insn_done_i[v]    = 1'b1;
        insn_done_id_i[v] = insn_id_t'(inflight[idx]);
        inflight.delete(idx);
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        int  fid = -1;
        bit  gnt, rdy, all_free = 1'b1;
        vfu_mask_t exp_vfu;
        @(negedge clk_i);
        for (int i = InsnIDNum - 1; i >= 0; i--) if (m_free[i]) fid = i;
        foreach (m_free[i]) all_free &= m_free[i];
        gnt     = m_held && !stall_i && vfu_ready_i[m_tgt];
        rdy     = (!m_held || gnt) && (fid >= 0);
        exp_vfu = gnt ? vfu_mask_t'(1 << m_tgt) : '0;
        check("valid", 64'(issue_valid_o), 64'(m_held));
        check("gnt", 64'(issue_req_gnt_o), 64'(gnt));
        check("dec_ready", 64'(dec_ready_o), 64'(rdy));
        check("vfu_valid", 64'(vfu_valid_o), 64'(exp_vfu));
        check("idle", 64'(idle_o), 64'(!m_held && all_free));
        if (m_held) check("issue_req", 64'(issue_req_o), 64'(m_req));
`ifdef VINSN_ISSUER_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cycles_o), 64'(m_stall));
`endif
        o_gnt = issue_req_gnt_o;
        o_rdy = dec_ready_o;
        o_id  = issue_req_o.insn_id;
        o_vfu = vfu_valid_o;
        @(posedge clk_i);
        if (rst_i) begin
            model_reset();
        end else begin
            if (gnt) inflight.push_back(int'(m_req.insn_id));
            for (int v = 0; v < NrVFU; v++) if (insn_done_i[v]) m_free[insn_done_id_i[v]] = 1'b1;
            if (m_held && !gnt && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (dec_valid_i && rdy) begin
                m_free[fid]   = 1'b0;
                m_req         = dec_req_i;
                m_req.insn_id = insn_id_t'(fid);
                m_tgt         = tgt_of(dec_vfu_i);
                m_held        = 1'b1;
            end else if (gnt) begin
                m_held = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        rst_i          = 1'b1;
        dec_req_i      = '0;
        dec_vfu_i      = 2'b01;
        dec_valid_i    = 1'b0;
        stall_i        = 1'b0;
        vfu_ready_i    = 2'b11;
        insn_done_i    = '0;
        insn_done_id_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        check("rst_valid", 64'(issue_valid_o), 64'(0));
        check("rst_gnt", 64'(issue_req_gnt_o), 64'(0));
        check("rst_vfu_valid", 64'(vfu_valid_o), 64'(0));
        check("rst_ready", 64'(dec_ready_o), 64'(1));
        check("rst_idle", 64'(idle_o), 64'(1));
`ifdef VINSN_ISSUER_STALL_CNT_EN
        check("rst_stall_cnt", 64'(stall_cycles_o), 64'(0));
`endif

        // Back-to-back issue to VFU0: IDs 0..3, then the pool runs dry.
        for (int k = 0; k < 6; k++) begin
            dec_valid_i = 1'b1;
            dec_req_i   = rand_req();
            dec_vfu_i   = 2'b01;
            cycle();
            if (k >= 1 && k <= 4) begin
                check("b2b_gnt", 64'(o_gnt), 64'(1));
                check("b2b_id", 64'(o_id), 64'(k - 1));
            end
            if (k >= 4) check("b2b_exhausted", 64'(o_rdy), 64'(0));
        end

        // Retire ID 2: not allocatable in the retire cycle, reused the cycle after.
        insn_done_i       = 2'b01;
        insn_done_id_i[0] = 2;
        drop(2);
        cycle();
        check("reuse_same_cycle", 64'(o_rdy), 64'(0));
        insn_done_i = '0;
        dec_req_i   = rand_req();
        cycle();
        check("reuse_next_cycle", 64'(o_rdy), 64'(1));

        // Scoreboard stall holds the instruction for three cycles.
        dec_valid_i = 1'b0;
        stall_i     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_gnt", 64'(o_gnt), 64'(0));
            check("stall_id", 64'(o_id), 64'(2));
        end
        stall_i = 1'b0;
        cycle();
        check("stall_release_gnt", 64'(o_gnt), 64'(1));
`ifdef VINSN_ISSUER_STALL_CNT_EN
        check("stall_cnt_3", 64'(stall_cycles_o), 64'(3));
`endif

        insn_done_i    = 2'b11;
        insn_done_id_i = {insn_id_t'(2), insn_id_t'(1)};
        drop(1);
        drop(2);
        cycle();
        insn_done_i = '0;

        // Target VFU1 not ready until bit 1 of vfu_ready_i rises.
        dec_valid_i = 1'b1;
        dec_req_i   = rand_req();
        dec_vfu_i   = 2'b10;
        vfu_ready_i = 2'b01;
        cycle();
        dec_valid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("tgt_busy_gnt", 64'(o_gnt), 64'(0));
        end
        vfu_ready_i = 2'b11;
        cycle();
        check("tgt_dispatch", 64'(o_vfu), 64'(2'b10));
        check("tgt_id", 64'(o_id), 64'(1));
        cycle();
        check("tgt_one_shot", 64'(o_vfu), 64'(0));

        // Two retires (IDs 0 and 3) in the same cycle as a capture: capture takes ID 2.
        dec_valid_i    = 1'b1;
        dec_req_i      = rand_req();
        dec_vfu_i      = 2'b01;
        insn_done_i    = 2'b11;
        insn_done_id_i = {insn_id_t'(3), insn_id_t'(0)};
        drop(0);
        drop(3);
        cycle();
        check("simul_ready", 64'(o_rdy), 64'(1));
        insn_done_i = '0;
        dec_req_i   = rand_req();
        cycle();
        check("simul_id", 64'(o_id), 64'(2));
        dec_valid_i = 1'b0;
        stall_i     = 1'b1;
        cycle();
        check("simul_freed_id", 64'(o_id), 64'(0));

        // Reset while an instruction is held.
        rst_i = 1'b1;
        cycle();
        rst_i   = 1'b0;
        stall_i = 1'b0;
        check("midrst_valid", 64'(issue_valid_o), 64'(0));
        check("midrst_idle", 64'(idle_o), 64'(1));
        check("midrst_ready", 64'(dec_ready_o), 64'(1));
        cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_i       = ($urandom_range(199) == 0);
            dec_valid_i = ($urandom_range(9) < 7);
            dec_req_i   = rand_req();
            dec_vfu_i   = vfu_mask_t'(1 << $urandom_range(NrVFU - 1));
            stall_i     = ($urandom_range(3) == 0);
            vfu_ready_i = vfu_mask_t'($urandom);
            insn_done_i = '0;
            for (int v = 0; v < NrVFU; v++) if ($urandom_range(2) == 0) retire_pick(v);
            cycle();
        end
        rst_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
